// File: rtl/uart_loader.sv
// UART program loader: receives 2-byte frames and emits program memory writes or pointer loads.
// Optional even-parity (8E1) receive format is enabled by defining LOADER_PARITY_EN; default is 8N1.
module uart_loader #(
  parameter int ADDR_WIDTH        = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter int CLKS_PER_BIT      = 868,
  parameter int TIMEOUT_CLKS      = 20 * CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  program_write,
  output logic [DATA_WIDTH-1:0] program_cmd,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  busy,
  output logic                  frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef LOADER_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic A_WAIT_HI = 1'b0;
  localparam logic A_WAIT_LO = 1'b1;

  logic          rx_meta, rx_sync, rx_prev;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_valid, rx_err, fall_pend;
  logic          fall, stop_ok;

  assign fall = rx_prev & ~rx_sync;

`ifdef LOADER_PARITY_EN
  logic par_bad;
  assign stop_ok = rx_sync & ~par_bad;
`else
  assign stop_ok = rx_sync;
`endif

  // Receiver: sample mid-bit, phase set by the synchronized start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
      fall_pend  <= 1'b0;
`ifdef LOADER_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt       <= '0;
          fall_pend <= 1'b0;
          if (fall || fall_pend) state <= S_START;
        end
        S_START: begin
          if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef LOADER_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef LOADER_PARITY_EN
        S_PARITY: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            par_bad <= rx_sync ^ (^shreg);
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          // An edge seen here belongs to the next byte; carry it into IDLE.
          if (fall) fall_pend <= 1'b1;
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (stop_ok) byte_valid <= 1'b1;
            else         rx_err     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic                         asm_st;
  logic [ADDR_WIDTH-1:0]        ptr;
  logic [TW-1:0]                tcnt;
  logic [INSTRUCTION_WIDTH-1:0] opcode;
  logic                         is_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_st        <= A_WAIT_HI;
      ptr           <= '0;
      tcnt          <= '0;
      opcode        <= '0;
      is_set        <= 1'b0;
      program_write <= 1'b0;
      program_cmd   <= '0;
      write_address <= '0;
      frame_err     <= 1'b0;
    end else begin
      program_write <= 1'b0;
      frame_err     <= 1'b0;
      if (program_write) ptr <= ptr + ADDR_WIDTH'(1);
      case (asm_st)
        A_WAIT_HI: begin
          tcnt <= '0;
          if (byte_valid) begin
            if (shreg[7:4] == 4'h0 || shreg[7:4] == 4'hA) begin
              opcode <= INSTRUCTION_WIDTH'(shreg[3:0]);
              is_set <= (shreg[7:4] == 4'hA);
              asm_st <= A_WAIT_LO;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (rx_err) begin
            frame_err <= 1'b1;
          end
        end
        default: begin
          if (byte_valid) begin
            asm_st <= A_WAIT_HI;
            if (is_set) begin
              ptr <= ADDR_WIDTH'(shreg);
            end else begin
              program_write <= 1'b1;
              program_cmd   <= DATA_WIDTH'({opcode, ADDR_WIDTH'(shreg)});
              write_address <= ptr;
            end
          end else if (rx_err || tcnt == TW'(TIMEOUT_CLKS - 1)) begin
            asm_st    <= A_WAIT_HI;
            frame_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE) | (asm_st == A_WAIT_LO);

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: frame table plus scoreboard of expected writes,
// with hand-written sequences for timeout, framing errors, glitches, parity and reset.
module tb_uart_loader;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        program_write;
  logic [11:0] program_cmd;
  logic [7:0]  write_address;
  logic        busy, frame_err;

  uart_loader #(.ADDR_WIDTH(8), .INSTRUCTION_WIDTH(4), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(80)) dut (
    .clk(clk), .reset(reset), .rx(rx), .program_write(program_write),
    .program_cmd(program_cmd), .write_address(write_address), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] cmd; logic [7:0] addr; } wr_t;
  typedef struct { logic [7:0] hi; logic [7:0] lo; logic wr; logic [11:0] cmd; logic [7:0] addr; } vec_t;

  wr_t exp_q[$];
  int  checks = 0, errors = 0, err_seen = 0, e0;
  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err === 1'b1) err_seen++;
      if (program_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got cmd %0h addr %0h want no write", program_cmd, write_address);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_cmd", {20'd0, program_cmd}, {20'd0, e.cmd});
          chk("write_addr", {24'd0, write_address}, {24'd0, e.addr});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop_bit = 1'b1, input logic par = 1'b0, input logic use_par = 1'b0);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef LOADER_PARITY_EN
    rx = use_par ? par : ^d;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'h03, 8'h2C, 1'b1, 12'h32C, 8'h00};
    vt[1] = '{8'hA0, 8'hFF, 1'b0, 12'h000, 8'h00};
    vt[2] = '{8'h01, 8'h05, 1'b1, 12'h105, 8'hFF};
    vt[3] = '{8'h02, 8'h06, 1'b1, 12'h206, 8'h00};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_write", program_write, 0);
    chk("rst_cmd", program_cmd, 0);
    chk("rst_addr", write_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);

    // Basic write, set-address, and pointer wrap.
    for (int i = 0; i < 4; i++) begin
      if (vt[i].wr) exp_q.push_back('{vt[i].cmd, vt[i].addr});
      send_byte(vt[i].hi);
      send_byte(vt[i].lo);
    end
    drain("table_drain");
    chk("table_errs", err_seen, 0);
    chk("hold_cmd", program_cmd, 12'h206);
    chk("hold_addr", write_address, 8'h00);

    // Timeout between high and low byte.
    e0 = err_seen;
    send_byte(8'h03);
    chk("wait_lo_busy", busy, 1);
    repeat (100) @(negedge clk);
    chk("timeout_err", err_seen - e0, 1);
    chk("timeout_busy", busy, 0);
    exp_q.push_back('{12'h107, 8'h01});
    send_byte(8'h01);
    send_byte(8'h07);
    drain("timeout_drain");

    // Bad stop bit and bad tag; pointer must stay at 2.
    e0 = err_seen;
    send_byte(8'h01, 1'b0);
    send_byte(8'h53);
    chk("reject_errs", err_seen - e0, 2);
    exp_q.push_back('{12'h411, 8'h02});
    send_byte(8'h04);
    send_byte(8'h11);
    drain("reject_drain");

    // One-cycle glitch on rx.
    e0 = err_seen;
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_busy", busy, 0);
    chk("glitch_errs", err_seen - e0, 0);

`ifdef LOADER_PARITY_EN
    e0 = err_seen;
    send_byte(8'h03, 1'b1, 1'b0, 1'b1);
    send_byte(8'h2C, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("parity_errs", err_seen - e0, 1);
    chk("parity_busy", busy, 0);
`endif

    // Reset in the middle of a byte.
    e0 = err_seen;
    @(negedge clk) rx = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_write", program_write, 0);
    chk("mid_rst_cmd", program_cmd, 0);
    chk("mid_rst_addr", write_address, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ferr", frame_err, 0);
    rx = 1'b1;
    @(negedge clk) reset = 1'b0;
    exp_q.push_back('{12'h32C, 8'h00});
    send_byte(8'h03);
    send_byte(8'h2C);
    drain("post_rst_drain");
    chk("post_rst_errs", err_seen - e0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
